cordic_angle_reducer: RTL and testbench
=======================================

// Module: cordic_angle_reducer
// PURPOSE
//  Upstream feeder for cordic_engine. Takes an arbitrary signed Q3.29 angle in [-4,4) rad.
//  Reduces it to [-pi/2,pi/2] and derives the output negation bits.
//  Issues exactly one angle_valid pulse per angle, then holds angle/sign stable for the whole engine run.
//  Paces issues so the engine only sees a new angle when it is back in IDLE; flags when sine/cosine are valid.
// PARAMETERS
//  ENGINE_LAT  34  cycles from angle_valid pulse until engine sine/cosine valid and engine back in IDLE
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high
//  in_angle     in   32  signed Q3.29 angle, sampled on in_valid&in_ready
//  in_valid     in   1   upstream angle valid
//  in_ready     out  1   block can accept an angle this cycle
//  angle        out  32  reduced signed Q3.29 angle to engine, range [-pi/2,pi/2]
//  sign         out  2   [0]=negate cosine, [1]=negate sine; to engine sign port
//  angle_valid  out  1   single-cycle start strobe to engine
//  res_valid    out  1   single-cycle pulse: engine sine/cosine valid this cycle
//  busy         out  1   high from acceptance until res_valid of the last queued angle
// BEHAVIOUR
//  Reset (async): state=IDLE; angle=0, sign=0, angle_valid=0, res_valid=0, busy=0, in_ready=1, buffer empty.
//  Constants (Q3.29): PI=0x6487ED51, PI_2=0x3243F6A9, TWO_PI=0x0C90FDAA2 (33-bit). Arithmetic is 33-bit signed.
//  States:
//   IDLE   in_ready=1; on in_valid: latch sext(in_angle) -> WRAP.
//   WRAP   a>=PI: a-=TWO_PI; a<-PI: a+=TWO_PI; result in [-PI,PI) -> FOLD.
//   FOLD   a>PI_2: angle=PI-a, sign=01; a<-PI_2: angle=-PI-a, sign=01; else angle=a[31:0], sign=00 -> ISSUE.
//   ISSUE  angle_valid=1 for exactly one cycle; load wait counter with ENGINE_LAT-1 -> WAIT.
//   WAIT   count down; angle/sign held unchanged (engine samples sign at its DONE state).
//          At 0: res_valid=1 for one cycle; go to WRAP if buffer holds an angle, else IDLE.
//  sign[1] is always 0: the fold never needs sine negation.
//  Boundaries:
//   a==PI_2 passes unchanged.
//   a==PI wraps to -PI+ and folds to angle=0, sign=01.
//   a==-PI folds to angle=0, sign=01.
//  Latency: acceptance at C -> angle_valid at C+3 -> res_valid at C+3+ENGINE_LAT (C+37 default).
//  Pacing: angle_valid is never reasserted within ENGINE_LAT cycles of the previous pulse.
//  in_valid while in_ready=0 is ignored; upstream must hold it.
//  Reset mid-run: aborts immediately; angle_valid drops same instant, no res_valid. The engine must be reset alongside.
// CONFIGURATION
//  CORDIC_INBUF_EN defined: one-entry pending buffer.
//   in_ready = buffer empty in every state; an angle may be accepted while WRAP..WAIT is active.
//   Buffered angle enters WRAP the cycle after res_valid, so angle_valid pulses are spaced ENGINE_LAT+3 apart.
//   Accepting in the same cycle the buffer drains is allowed: in_ready uses the registered empty flag.
//  CORDIC_INBUF_EN undefined: no buffer; in_ready=1 only in IDLE; next acceptance earliest at the res_valid cycle.
// TESTING
//  1. in_angle=0x1921FB54 (pi/4) -> angle=0x1921FB54, sign=00, angle_valid at C+3, res_valid at C+37.
//  2. in_angle=0x4B65F1FD (3pi/4) -> angle=0x1921FB54, sign=01.
//  3. in_angle=0x7FFFFFFF (~4.0) -> wrap then fold: angle=0xE487ED52, sign=01.
//  4. in_angle=0x6487ED51 (PI) -> angle=0x00000000, sign=01; in_angle=0x3243F6A9 -> unchanged, sign=00.
//  5. Back-to-back in_valid with CORDIC_INBUF_EN: second accepted at C+1, in_ready=0 after.
//     angle_valid pulses at C+3 and C+40; res_valid at C+37 and C+74.
//     Without the macro, second accept occurs at C+37.
//  6. rst pulsed at C+10 during WAIT -> all outputs 0 at once, no res_valid.
//     Next in_valid behaves as a fresh case 1.

Source files
------------

// File: rtl/cordic_angle_reducer.sv
// rtl/cordic_angle_reducer.sv - reduces a Q3.29 angle to [-pi/2,pi/2] and paces starts into cordic_engine
// Optional one-entry pending buffer enabled by defining CORDIC_INBUF_EN.
module cordic_angle_reducer #(
  parameter int ENGINE_LAT = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_angle,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] angle,
  output logic [1:0]  sign,
  output logic        angle_valid,
  output logic        res_valid,
  output logic        busy
);

  localparam int CW = $clog2(ENGINE_LAT);

  localparam logic signed [32:0] PI     = 33'sh06487ED51;
  localparam logic signed [32:0] PI_2   = 33'sh03243F6A9;
  localparam logic signed [32:0] TWO_PI = 33'sh0C90FDAA2;
  localparam logic signed [32:0] NEG_PI   = -PI;
  localparam logic signed [32:0] NEG_PI_2 = -PI_2;
  localparam logic [31:0] PI32     = 32'h6487ED51;
  localparam logic [31:0] NEG_PI32 = 32'h9B7812AF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRAP,
    S_FOLD,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic signed [32:0] a_q, a_d;
  logic [31:0]        angle_q, angle_d;
  logic [1:0]         sign_q, sign_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
`ifdef CORDIC_INBUF_EN
  logic [31:0]        buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      angle_q <= '0;
      sign_q  <= '0;
      cnt_q   <= '0;
`ifdef CORDIC_INBUF_EN
      buf_q      <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      angle_q <= angle_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
`ifdef CORDIC_INBUF_EN
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    angle_d     = angle_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    angle_valid = 1'b0;
    res_valid   = 1'b0;
`ifdef CORDIC_INBUF_EN
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    // Registered empty flag only, so readiness never depends on in_valid.
    in_ready    = !buf_full_q;
`else
    in_ready    = (state_q == S_IDLE) || (state_q == S_WAIT && cnt_q == '0);
`endif
    accept      = in_valid && in_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = {in_angle[31], in_angle};
          state_d = S_WRAP;
        end
      end
      S_WRAP: begin
        if (a_q >= PI) begin
          a_d = a_q - TWO_PI;
        end else if (a_q < NEG_PI) begin
          a_d = a_q + TWO_PI;
        end
        state_d = S_FOLD;
      end
      S_FOLD: begin
        // Folded results always fit 32 bits, so modular 32-bit subtraction is exact.
        if (a_q > PI_2) begin
          angle_d = PI32 - a_q[31:0];
          sign_d  = 2'b01;
        end else if (a_q < NEG_PI_2) begin
          angle_d = NEG_PI32 - a_q[31:0];
          sign_d  = 2'b01;
        end else begin
          angle_d = a_q[31:0];
          sign_d  = 2'b00;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        angle_valid = 1'b1;
        cnt_d       = CW'(ENGINE_LAT - 1);
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_valid = 1'b1;
`ifdef CORDIC_INBUF_EN
          if (buf_full_q) begin
            a_d        = {buf_q[31], buf_q};
            buf_full_d = 1'b0;
            state_d    = S_WRAP;
          end else
`endif
          if (accept) begin
            a_d     = {in_angle[31], in_angle};
            state_d = S_WRAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CORDIC_INBUF_EN
    // Angles arriving while the pipeline is occupied wait in the buffer.
    if (accept && state_q != S_IDLE && !(state_q == S_WAIT && cnt_q == '0)) begin
      buf_d      = in_angle;
      buf_full_d = 1'b1;
    end
`endif
  end

  assign angle = angle_q;
  assign sign  = sign_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// tb/tb_cordic_angle_reducer.sv - scoreboard bench for cordic_angle_reducer
module tb_cordic_angle_reducer;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_angle = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] angle;
  logic [1:0]  sign;
  logic        angle_valid;
  logic        res_valid;
  logic        busy;

  cordic_angle_reducer dut (
    .clk(clk), .rst(rst), .in_angle(in_angle), .in_valid(in_valid), .in_ready(in_ready),
    .angle(angle), .sign(sign), .angle_valid(angle_valid), .res_valid(res_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ang;
    logic [1:0]  sg;
    int          cyc;
  } exp_t;

  exp_t eq[$];
  exp_t rq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   last_issue = -1000;
  int   last_acc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: wrap into [-pi,pi), then mirror about +-pi/2 flipping the cosine sign.
  function automatic void model(input logic [31:0] x, output logic [31:0] ea, output logic [1:0] es);
    longint a, r;
    longint pi_v = 64'd1686629713;
    longint half = 64'd843314857;
    longint two  = 64'd3373259426;
    a  = longint'(signed'(x));
    es = 2'b00;
    if (a >= pi_v) a = a - two;
    else if (a < -pi_v) a = a + two;
    if (a > half) begin
      r = pi_v - a; es = 2'b01;
    end else if (a < -half) begin
      r = -pi_v - a; es = 2'b01;
    end else begin
      r = a;
    end
    ea = r[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (angle_valid) begin
        if (eq.size() == 0) begin
          chk("unexpected angle_valid", 1, 0);
        end else begin
          mon_e = eq.pop_front();
          chk("issue cycle", cyc, mon_e.cyc);
          chk("angle", angle, mon_e.ang);
          chk("sign", sign, mon_e.sg);
          mon_e.cyc = cyc + LAT;
          rq.push_back(mon_e);
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected res_valid", 1, 0);
        end else begin
          mon_e = rq.pop_front();
          chk("res cycle", cyc, mon_e.cyc);
          chk("angle held", angle, mon_e.ang);
          chk("sign held", sign, mon_e.sg);
          chk("busy at res", busy, 1);
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] ea, input logic [1:0] es);
    int   n = 0;
    int   iss;
    exp_t e;
    in_angle = x;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    last_acc = cyc;
    iss = (cyc + 3 > last_issue + LAT + 3) ? cyc + 3 : last_issue + LAT + 3;
    last_issue = iss;
    e.ang = ea; e.sg = es; e.cyc = iss;
    eq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [31:0] x);
    logic [31:0] ea;
    logic [1:0]  es;
    model(x, ea, es);
    send(x, ea, es);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((eq.size() != 0 || rq.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < 300, 1);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bounds [8] = '{32'h3243F6A9, 32'hCDBC0957, 32'h9B7812AF, 32'h6487ED50,
                              32'h80000000, 32'hCDBC0956, 32'h3243F6AA, 32'h00000000};

  initial begin
    int c1;
    #3;
    chk("rst angle_valid", angle_valid, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst angle", angle, 0);
    chk("rst sign", sign, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    send(32'h1921FB54, 32'h1921FB54, 2'b00);
    wait_idle();
    chk("busy idle", busy, 0);
    send(32'h4B65F1FD, 32'h1921FB54, 2'b01);
    wait_idle();
    send(32'h7FFFFFFF, 32'hE487ED52, 2'b01);
    wait_idle();
    send(32'h6487ED51, 32'h00000000, 2'b01);
    send(32'h3243F6A9, 32'h3243F6A9, 2'b00);
    wait_idle();

    send(32'h1921FB54, 32'h1921FB54, 2'b00);
    c1 = last_acc;
    send(32'h4B65F1FD, 32'h1921FB54, 2'b01);
    @(negedge clk);
`ifdef CORDIC_INBUF_EN
    chk("second accept", last_acc, c1 + 1);
`else
    chk("second accept", last_acc, c1 + LAT + 3);
`endif
    chk("in_ready after second", in_ready, 0);
    wait_idle();

    send(32'h1921FB54, 32'h1921FB54, 2'b00);
    c1 = last_acc;
    while (cyc < c1 + 10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst angle_valid", angle_valid, 0);
    chk("midrst res_valid", res_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst angle", angle, 0);
    chk("midrst sign", sign, 0);
    eq.delete();
    rq.delete();
    last_issue = -1000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    #1;
    send(32'h1921FB54, 32'h1921FB54, 2'b00);
    wait_idle();

    foreach (bounds[i]) send_rand(bounds[i]);
    for (int i = 0; i < 30; i++) begin
      send_rand($urandom());
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(30, 45)) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_idle();
    chk("queues empty", eq.size() + rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
